sh_recombine_monitor: RTL

//  Parametrised, sequential debug monitor for masked datapaths. Each accepted beat is NBYTES bytes
//  of d-share data; the monitor XOR-recombines it to plain bytes and registers the result.

---
 rtl/sh_recombine_monitor_if.sv | 41 ++++
 rtl/sh_recombine_monitor.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sh_recombine_monitor_if.sv
// Bundle of the beat-input, result and log-readback signals of sh_recombine_monitor.
// The monitor uses the slave modport; whoever feeds beats and pops the log uses master.
interface sh_recombine_monitor_if #(
    parameter int d      = 2,
    parameter int NBYTES = 4,
    parameter int DEPTH  = 16
);
    localparam int W  = 8 * NBYTES;
    localparam int LW = $clog2(DEPTH) + 1;

    // in_valid/in_ready: a beat (sh_in, cmp_en, exp_word) transfers on a rising edge
    // where both are high; the source holds the beat until then. rd_en is a
    // fire-and-forget pop request answered by a one-cycle rd_valid pulse.
    logic            in_valid;
    logic            in_ready;
    logic [W*d-1:0]  sh_in;
    logic            cmp_en;
    logic [W-1:0]    exp_word;
    logic            plain_valid;
    logic [W-1:0]    plain_word;
    logic            mismatch;
    logic [15:0]     mis_count;
    logic            rd_en;
    logic            rd_valid;
    logic [W-1:0]    rd_data;
    logic [LW-1:0]   level;
    logic            overflow;
    logic            underflow;

    modport master (
        output in_valid, sh_in, cmp_en, exp_word, rd_en,
        input  in_ready, plain_valid, plain_word, mismatch, mis_count,
               rd_valid, rd_data, level, overflow, underflow
    );

    modport slave (
        input  in_valid, sh_in, cmp_en, exp_word, rd_en,
        output in_ready, plain_valid, plain_word, mismatch, mis_count,
               rd_valid, rd_data, level, overflow, underflow
    );
endinterface

// File: rtl/sh_recombine_monitor.sv
// Debug monitor: XOR-recombines d-share beats to plain bytes, optionally compares them
// against an expected word, and keeps the plain beats in a DEPTH-entry circular log.
module sh_recombine_monitor #(
    parameter int d         = 2,
    parameter int NBYTES    = 4,
    parameter int DEPTH     = 16,
    parameter bit STOP_FULL = 1'b0
) (
    input logic                 clk,
    input logic                 syn_rst,
    sh_recombine_monitor_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    logic [W-1:0]  plain_c;
    logic          full;
    logic          empty;
    logic          in_ready_c;
    logic          accept;
    logic          pop;
    logic          overwrite;
    logic          mismatch_c;

    logic          plain_valid_q;
    logic [W-1:0]  plain_q;
    logic [W-1:0]  exp_q;
    logic          cmp_en_q;
    logic [15:0]   mis_count_q;
    logic          rd_valid_q;
    logic [W-1:0]  rd_data_q;
    logic          overflow_q;
    logic          underflow_q;

    // Share k of plain bit b sits at d*b + k, so each plain bit is the XOR of one d-wide slice.
    always_comb begin
        plain_c = '0;
        for (int b = 0; b < W; b++) begin
            plain_c[b] = ^bus.sh_in[d*b +: d];
        end
    end

    assign full       = (level_q == FULL_LVL);
    assign empty      = (level_q == '0);
    assign in_ready_c = !(STOP_FULL && full);
    assign accept     = bus.in_valid & in_ready_c;
    assign pop        = bus.rd_en & !empty;
    // Only reachable with STOP_FULL=0: the newest beat evicts the oldest entry.
    assign overwrite  = accept & full & !pop;
    assign mismatch_c = plain_valid_q & cmp_en_q & (plain_q != exp_q);

    always_comb begin
        level_d = level_q;
        if (accept && !pop && !full) begin
            level_d = level_q + 1'b1;
        end else if (pop && !accept) begin
            level_d = level_q - 1'b1;
        end
    end

    // Log storage carries no reset; pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= plain_c;
        end
    end

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_q       <= '0;
            plain_valid_q <= 1'b0;
            plain_q       <= '0;
            exp_q         <= '0;
            cmp_en_q      <= 1'b0;
            mis_count_q   <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            level_q       <= level_d;
            plain_valid_q <= accept;
            rd_valid_q    <= pop;

            if (accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                plain_q  <= plain_c;
                exp_q    <= bus.exp_word;
                cmp_en_q <= bus.cmp_en;
            end

            // The read samples the array before this edge's write lands, so a
            // pop that collides with a write to the same slot returns the old entry.
            if (pop) begin
                rd_data_q <= mem[rd_ptr];
            end
            if (pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (overwrite) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow_q <= 1'b1;
            end

            if (mismatch_c && (mis_count_q != 16'hFFFF)) begin
                mis_count_q <= mis_count_q + 16'd1;
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.plain_valid = plain_valid_q;
    assign bus.plain_word  = plain_q;
    assign bus.mismatch    = mismatch_c;
    assign bus.mis_count   = mis_count_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule
